// File: rtl/tl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tl_pkg                                                               |
// | Shared light codes and state types for the traffic-light controller  |
// | and its street-side vehicle sensor front-end.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package tl_pkg;

   localparam logic [2:0] LT_GREEN  = 3'b100;
   localparam logic [2:0] LT_YELLOW = 3'b010;
   localparam logic [2:0] LT_RED    = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_SERVE = 2'd2,
      S_HOLD  = 2'd3
   } sns_state_t;

   typedef enum logic [1:0] {
      C_AV_GREEN  = 2'd0,
      C_AV_YELLOW = 2'd1,
      C_ST_GREEN  = 2'd2,
      C_ST_YELLOW = 2'd3
   } ctl_state_t;

   // Only the exact green code counts; illegal codes read as not green.
   function automatic logic is_green(input logic [2:0] st);
      return (st == LT_GREEN);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sen_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sen_debounce                                                         |
// | 2-FF synchroniser plus stable-count debouncer for the loop detector; |
// | emits a one-cycle arrival pulse on each accepted rising level.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sen_debounce #(
   parameter int DEB_CYC = 2500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_det,
   output logic det_clean,
   output logic arrival
);

   localparam int c_cnt_w = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DEB_CYC - 1);

   logic               r_sync1;
   logic               r_sync_q;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_det;
   logic               r_arrival;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1   <= 1'b0;
         r_sync_q  <= 1'b0;
         r_cnt     <= '0;
         r_det     <= 1'b0;
         r_arrival <= 1'b0;
      end else begin
         r_sync1   <= raw_det;
         r_sync_q  <= r_sync1;
         r_arrival <= 1'b0;
         if (r_sync_q != r_det) begin
            // Level accepted only after DEB_CYC consecutive differing cycles.
            if (r_cnt == c_last) begin
               r_det     <= r_sync_q;
               r_cnt     <= '0;
               r_arrival <= r_sync_q;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign det_clean = r_det;
   assign arrival   = r_arrival;

endmodule
`default_nettype wire

// File: rtl/veh_sensor_req.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | veh_sensor_req                                                       |
// | Street-side vehicle request front-end: debounced arrivals, waiting   |
// | count, and the sen request held until street green, then hold-off.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module veh_sensor_req #(
   parameter int DEB_CYC     = 2500000,
   parameter int HOLDOFF_CYC = 50000000,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             raw_det,
   input  logic [2:0]       St,
   output logic             sen,
   output logic             arrival,
   output logic [CNT_W-1:0] wait_cnt,
   output logic             det_clean,
   output logic [1:0]       sns_st
);

   import tl_pkg::*;

   localparam int c_hold_w = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
   localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLDOFF_CYC - 1);
   localparam logic [CNT_W-1:0]    c_wait_max  = {CNT_W{1'b1}};

   logic                w_arrival;
   logic                w_det_clean;
   logic                w_green;
   logic [CNT_W-1:0]    w_wait_inc;

   sns_state_t          r_state;
   logic [c_hold_w-1:0] r_hold;
   logic [CNT_W-1:0]    r_wait;
   logic                r_sen;

   sen_debounce #(
      .DEB_CYC   (DEB_CYC)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .raw_det   (raw_det),
      .det_clean (w_det_clean),
      .arrival   (w_arrival)
   );

   assign w_green    = is_green(St);
   assign w_wait_inc = (w_arrival && (r_wait != c_wait_max)) ? r_wait + 1'b1 : r_wait;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_hold  <= '0;
         r_wait  <= '0;
         r_sen   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_arrival) begin
                  r_wait  <= CNT_W'(1);
                  r_state <= S_REQ;
                  r_sen   <= 1'b1;
               end
            end
            S_REQ: begin
               // A vehicle arriving with green is served, so green wins.
               if (w_green) begin
                  r_state <= S_SERVE;
                  r_wait  <= '0;
                  r_sen   <= 1'b0;
               end else begin
                  r_wait <= w_wait_inc;
               end
            end
            S_SERVE: begin
               if (!w_green) begin
                  r_state <= S_HOLD;
                  r_hold  <= '0;
               end
            end
            S_HOLD: begin
               r_wait <= w_wait_inc;
               if (r_hold == c_hold_last) begin
                  if (w_wait_inc != '0) begin
                     r_state <= S_REQ;
                     r_sen   <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_sen   <= 1'b0;
            end
         endcase
      end
   end

   assign sen       = r_sen;
   assign arrival   = w_arrival;
   assign wait_cnt  = r_wait;
   assign det_clean = w_det_clean;
   assign sns_st    = r_state;

endmodule
`default_nettype wire
